if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset rst (synchronous, active-high), and SHALL have no parameters.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- ce_i  in  1  PC valid (PC register chip enable)
- pc_i  in  32  current PC from PC register
- flush_i  in  1  exception flush; kills in-flight fetch and held instruction
- id_stall_i  in  1  ID stage cannot accept an instruction this cycle
- inst_req  out  1  instruction bus request
- inst_addr  out  32  instruction bus address
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- pc_stall_o  out  1  drives PC register stall[0]; 0 = PC advances at this edge
- inst_valid_o  out  1  registered one-cycle pulse, instruction delivered to ID
- inst_o  out  32  delivered instruction
- inst_pc_o  out  32  PC of delivered instruction

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and DISCARD.
REQ-004 IDLE: inst_req=0; go to REQ when ce_i=1.
REQ-005 REQ: inst_req = !flush_i and inst_addr = pc_i (combinational); if ce_i=0 go to IDLE; on inst_addr_ok=1 with flush_i=0, latch pc_i into fetch_pc and go to WAIT.
REQ-006 WAIT: on inst_data_ok=1 with id_stall_i=0, deliver (REQ-009), drive pc_stall_o=0 and go to REQ.
REQ-007 WAIT: on inst_data_ok=1 with id_stall_i=1, capture inst_rdata and fetch_pc into a one-entry hold buffer and go to HOLD.
REQ-008 HOLD: when id_stall_i=0, deliver the buffer (REQ-009), drive pc_stall_o=0 and go to REQ.
REQ-009 Delivery SHALL register inst_o, inst_pc_o and inst_valid_o=1 at the same edge at which the PC advances; inst_valid_o SHALL be 0 on every other cycle, with inst_o and inst_pc_o holding their last values.
REQ-010 pc_stall_o SHALL be 1 in every cycle except a delivery cycle, and SHALL be 0 for exactly one cycle per delivered instruction.
REQ-011 At most one bus request SHALL be outstanding; inst_req SHALL be 0 in WAIT, HOLD and DISCARD.
REQ-012 inst_data_ok received in any state other than WAIT or DISCARD SHALL be ignored.
REQ-013 flush_i in REQ: no request is issued that cycle, and the FSM stays in REQ.
REQ-014 flush_i in WAIT with inst_data_ok=0: go to DISCARD.
REQ-015 flush_i in WAIT with inst_data_ok=1: drop the data, do not deliver, go to REQ.
REQ-016 flush_i in HOLD: drop the buffer, go to REQ.
REQ-017 flush_i in any state: no delivery that cycle, pc_stall_o=1, and inst_valid_o=0 at the next edge.
REQ-018 DISCARD: wait for inst_data_ok, drop the data without delivering and go to REQ; further flush_i pulses SHALL NOT change the state.
REQ-019 flush_i SHALL take priority over delivery whenever both occur in the same cycle.
REQ-020 Branch redirection SHALL require no special handling: the PC register applies its branch target on the pc_stall_o=0 edge, and the next REQ uses the new pc_i.

Reset
REQ-021 While rst=1 (synchronous): state=IDLE, fetch_pc=0, hold buffer=0, inst_o=0, inst_pc_o=0, inst_valid_o=0.
REQ-022 While rst=1: inst_req=0 and pc_stall_o=1.
REQ-023 Reset asserted mid-operation SHALL abandon any outstanding request; a late inst_data_ok arriving after reset SHALL be ignored (REQ-012).

Verification
REQ-024 Basic fetch: rst released, ce_i=1, pc_i=0xBFC00000, addr_ok on the first REQ cycle, data_ok next cycle with 0x3C08BFC0 -> one-cycle inst_valid_o pulse with inst_o=0x3C08BFC0 and inst_pc_o=0xBFC00000; pc_stall_o=0 in the data_ok cycle only.
REQ-025 Hold path: data_ok with id_stall_i=1 for 3 cycles -> FSM in HOLD, pc_stall_o=1 and no inst_req; delivery occurs in the cycle id_stall_i falls, with the original data and PC.
REQ-026 Flush in WAIT: flush_i one cycle after addr_ok, data_ok 2 cycles later -> no inst_valid_o, PC not advanced; next inst_req issued the cycle after data_ok.
REQ-027 Simultaneous events: flush_i in the same cycle as data_ok with id_stall_i=0 -> no delivery, pc_stall_o=1, FSM returns to REQ.
REQ-028 Back-to-back fetches with addr_ok and data_ok each a single cycle: PCs 0xBFC00000, 0xBFC00004, 0xBFC00008 delivered in order, one delivery every 2 cycles, and never more than one request outstanding.
REQ-029 Reset mid-WAIT: rst for 1 cycle, then a stale data_ok arrives -> ignored; all outputs at reset values; fetch restarts from pc_i.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch FSM between the PC register, the instruction bus and ID.
// Keeps one bus request in flight and buffers a single instruction while ID stalls.
module if_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic        id_stall_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        pc_stall_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DISCARD} state_t;
    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d, hold_pc_q, hold_pc_d;
    logic [31:0] inst_q, inst_d, inst_pc_q, inst_pc_d;
    logic        valid_q, deliver;

    assign inst_addr    = pc_i;
    assign pc_stall_o   = !deliver;
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        deliver     = 1'b0;
        inst_req    = 1'b0;
        case (state_q)
            IDLE: state_d = ce_i ? REQ : IDLE;
            REQ: begin
                inst_req = !flush_i;
                // An accepted request must be tracked even if ce_i drops the same cycle
                if (inst_addr_ok && !flush_i) begin
                    state_d    = WAIT;
                    fetch_pc_d = pc_i;
                end else if (!ce_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (inst_data_ok && flush_i) begin
                    state_d = REQ;
                end else if (inst_data_ok && id_stall_i) begin
                    state_d     = HOLD;
                    hold_inst_d = inst_rdata;
                    hold_pc_d   = fetch_pc_q;
                end else if (inst_data_ok) begin
                    state_d   = REQ;
                    deliver   = 1'b1;
                    inst_d    = inst_rdata;
                    inst_pc_d = fetch_pc_q;
                end else if (flush_i) begin
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_d = REQ;
                end else if (!id_stall_i) begin
                    state_d   = REQ;
                    deliver   = 1'b1;
                    inst_d    = hold_inst_q;
                    inst_pc_d = hold_pc_q;
                end
            end
            DISCARD: state_d = inst_data_ok ? REQ : DISCARD;
            default: state_d = IDLE;
        endcase
        if (rst) begin
            inst_req = 1'b0;
            deliver  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            valid_q     <= deliver;
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: random bus/ID/flush stimulus; a transaction-level model predicts
// which fetched words reach ID, in which cycle the PC advances, and queues expected deliveries.
module tb_if_fetch_ctrl;
    logic        clk = 1'b0, rst, ce_i, flush_i, id_stall_i;
    logic [31:0] pc_i, inst_addr, inst_rdata, inst_o, inst_pc_o;
    logic        inst_req, inst_addr_ok, inst_data_ok, pc_stall_o, inst_valid_o;

    if_fetch_ctrl dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .pc_i(pc_i), .flush_i(flush_i),
        .id_stall_i(id_stall_i), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .pc_stall_o(pc_stall_o), .inst_valid_o(inst_valid_o), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] d; logic [31:0] p;} exp_t;
    exp_t        exp_q[$];
    int          total = 0, bad = 0;
    logic        calm = 1'b1;
    logic        pend_v = 1'b0, pend_stale = 1'b0, pend_killed = 1'b0;
    logic [31:0] pend_pc = '0;
    int          pend_lat = 0;
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0, held_p = '0;
    logic        exp_valid = 1'b0, prev_rst = 1'b0;
    logic [31:0] pc_next = 32'hBFC00000;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'hBFC00000) ? 32'h3C08BFC0 : ({a[15:0], a[31:16]} ^ 32'hA5C30F17);
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // Monitor and reference model, sampled mid-cycle
    always @(negedge clk) begin
        logic        dv, dlv, consumed;
        logic [31:0] dd, dp;
        exp_t        e;
        dlv = 1'b0;
        chk("valid_pulse", {31'b0, inst_valid_o}, {31'b0, exp_valid});
        if (inst_valid_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_delivery: inst=%h pc=%h at %0t", inst_o, inst_pc_o, $time);
            end else begin
                e = exp_q.pop_front();
                chk("inst", inst_o, e.d);
                chk("inst_pc", inst_pc_o, e.p);
            end
        end
        if (prev_rst && !rst) begin
            chk("rst_inst", inst_o, 32'h0);
            chk("rst_inst_pc", inst_pc_o, 32'h0);
        end
        consumed = inst_data_ok && pend_v;
        if (rst) begin
            chk("rst_req", {31'b0, inst_req}, 32'h0);
            chk("rst_pc_stall", {31'b0, pc_stall_o}, 32'h1);
            if (pend_v) pend_stale = 1'b1;
            held_v = 1'b0;
        end else begin
            chk("one_outstanding", {31'b0, inst_req && ((pend_v && !pend_stale) || held_v || flush_i)}, 32'h0);
            if (inst_req) chk("addr", inst_addr, pc_i);
            dv = held_v;
            dd = held_d;
            dp = held_p;
            if (consumed && !pend_stale && !pend_killed && !flush_i) begin
                dv = 1'b1;
                dd = mem(pend_pc);
                dp = pend_pc;
            end
            if (pend_v && flush_i) pend_killed = 1'b1;
            if (flush_i) dv = 1'b0;
            dlv = dv && !id_stall_i;
            chk("pc_stall", {31'b0, pc_stall_o}, {31'b0, !dlv});
            if (dlv) begin
                exp_q.push_back('{d: dd, p: dp});
                dv = 1'b0;
                pc_next = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFFFFFC) : pc_i + 32'd4;
            end
            held_v = dv;
            held_d = dd;
            held_p = dp;
        end
        if (consumed) pend_v = 1'b0;
        else if (pend_v && pend_lat != 0) pend_lat--;
        if (!rst && inst_req && inst_addr_ok && !pend_v) begin
            pend_v      = 1'b1;
            pend_pc     = pc_i;
            pend_stale  = 1'b0;
            pend_killed = 1'b0;
            pend_lat    = calm ? 0 : $urandom_range(0, 3);
        end
        exp_valid = dlv;
        prev_rst  = rst;
    end

    initial begin
        rst = 1'b1;
        ce_i = 1'b0;
        pc_i = 32'hBFC00000;
        flush_i = 1'b0;
        id_stall_i = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata = '0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            #1;
            calm         = c < 40;
            rst          = (c < 3) || (!calm && $urandom_range(0, 299) == 0);
            pc_i         = pc_next;
            ce_i         = calm || $urandom_range(0, 19) != 0;
            flush_i      = !calm && $urandom_range(0, 11) == 0;
            id_stall_i   = calm ? (c >= 20 && c < 24) : ($urandom_range(0, 2) == 0);
            inst_addr_ok = !pend_v && (calm || $urandom_range(0, 1) == 1);
            inst_data_ok = pend_v ? (pend_lat == 0) : ($urandom_range(0, 15) == 0);
            inst_rdata   = pend_v ? mem(pend_pc) : $urandom;
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        inst_data_ok = 1'b0;
        inst_addr_ok = 1'b0;
        id_stall_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
